npu_conv_reader: RTL and testbench

Parametrised read/write-back sequencer for one NPU convolution layer. It generalises the layer-1/2 memory reader to any channel count, image size, kernel size and address width. It walks a KxK window over an IMG_W x IMG_H image held in NCH parallel image RAMs and streams pixel/weight pairs to the MAC array with first/last tap markers. After each window it sequences the NCH accumulator write-backs into the store RAM.

---
 rtl/npu_pkg.sv | 51 +++++
 rtl/npu_conv_reader_if.sv | 43 ++++
 rtl/npu_win_addr_gen.sv | 127 ++++++++++++
 rtl/npu_conv_reader.sv | 193 +++++++++++++++++++
 tb/tb_npu_conv_reader.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared types and derived-geometry helpers for the NPU convolution reader.
// NPU_CONV_READER_PAD_EN selects "same" zero padding instead of valid convolution.
package npu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : clog2(n);
  endfunction

  function automatic int pad_of(input int k);
`ifdef NPU_CONV_READER_PAD_EN
    return (k - 1) / 2;
`else
    return 0 * k;
`endif
  endfunction

  function automatic int out_dim(input int img, input int k);
`ifdef NPU_CONV_READER_PAD_EN
    return img + 0 * k;
`else
    return img - k + 1;
`endif
  endfunction

  function automatic int taps(input int k);
    return k * k;
  endfunction

  function automatic int plane(input int img_w, input int img_h, input int k);
    return out_dim(img_w, k) * out_dim(img_h, k);
  endfunction

endpackage

// File: rtl/npu_conv_reader_if.sv
// Bus bundle between the convolution reader, its RAMs, the MAC array and the store RAM.
// NPU_CONV_READER_PAD_EN does not change this interface.
interface npu_conv_reader_if import npu_pkg::*; #(
  parameter int NCH    = 4,
  parameter int DW     = 8,
  parameter int IMG_AW = 10,
  parameter int PAR_AW = 15,
  parameter int ST_AW  = 14
) ();
  localparam int RNW = cw(NCH);

  logic                start;
  logic [PAR_AW-1:0]   param_base;
  logic [ST_AW-1:0]    out_base;
  logic [NCH*DW-1:0]   read_image;
  logic [DW-1:0]       read_conv;
  logic [IMG_AW-1:0]   image_ram_addr;
  logic [PAR_AW-1:0]   conv_ram_addr;
  logic [NCH*DW-1:0]   out_pixel;
  logic [DW-1:0]       out_param;
  logic                mac_valid;
  logic                mac_first;
  logic                mac_last;
  logic                wr_en;
  logic [RNW-1:0]      reg_num;
  logic [ST_AW-1:0]    ram_store_addr;
  logic                busy;
  logic                done;

  modport master (
    input  start, param_base, out_base, read_image, read_conv,
    output image_ram_addr, conv_ram_addr, out_pixel, out_param,
           mac_valid, mac_first, mac_last, wr_en, reg_num, ram_store_addr,
           busy, done
  );

  modport slave (
    output start, param_base, out_base, read_image, read_conv,
    input  image_ram_addr, conv_ram_addr, out_pixel, out_param,
           mac_valid, mac_first, mac_last, wr_en, reg_num, ram_store_addr,
           busy, done
  );
endinterface

// File: rtl/npu_win_addr_gen.sv
// Window/tap counters and registered image/parameter RAM address generation.
// With NPU_CONV_READER_PAD_EN defined, out-of-image taps drive address 0 and raise oob_o.
module npu_win_addr_gen import npu_pkg::*; #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 3,
  parameter int IMG_AW = 10,
  parameter int PAR_AW = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_i,
  input  logic              step_i,
  input  logic              next_win_i,
  input  logic [PAR_AW-1:0] param_base_i,
  output logic [IMG_AW-1:0] image_addr_o,
  output logic [PAR_AW-1:0] conv_addr_o,
`ifdef NPU_CONV_READER_PAD_EN
  output logic              oob_o,
`endif
  output logic              first_tap_o,
  output logic              last_tap_o,
  output logic              last_win_o
);
  localparam int OUT_W = out_dim(IMG_W, K);
  localparam int OUT_H = out_dim(IMG_H, K);
  localparam int P     = pad_of(K);
  localparam int KW    = cw(K);
  localparam int XW    = cw(OUT_W);
  localparam int YW    = cw(OUT_H);

  logic [KW-1:0]     kx_q, kx_d, ky_q, ky_d;
  logic [XW-1:0]     ox_q, ox_d;
  logic [YW-1:0]     oy_q, oy_d;
  logic [PAR_AW-1:0] pbase_q, pbase_d;
  logic [IMG_AW-1:0] img_q, img_d;
  logic [PAR_AW-1:0] conv_q, conv_d;
  logic              load;
  int                ix, iy;
`ifdef NPU_CONV_READER_PAD_EN
  logic              oob_q, oob_d;
`endif

  always_comb begin
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    pbase_d = pbase_q;
    load    = 1'b0;
    if (init_i) begin
      kx_d    = '0;
      ky_d    = '0;
      ox_d    = '0;
      oy_d    = '0;
      pbase_d = param_base_i;
      load    = 1'b1;
    end else if (next_win_i) begin
      kx_d = '0;
      ky_d = '0;
      load = 1'b1;
      if (ox_q == XW'(OUT_W - 1)) begin
        ox_d = '0;
        oy_d = oy_q + 1'b1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end else if (step_i) begin
      load = 1'b1;
      if (kx_q == KW'(K - 1)) begin
        kx_d = '0;
        ky_d = ky_q + 1'b1;
      end else begin
        kx_d = kx_q + 1'b1;
      end
    end
  end

  // Addresses are computed from the next counter values so they register in step with them.
  always_comb begin
    ix = int'(ox_d) + int'(kx_d) - P;
    iy = int'(oy_d) + int'(ky_d) - P;
`ifdef NPU_CONV_READER_PAD_EN
    oob_d = (ix < 0) || (ix >= IMG_W) || (iy < 0) || (iy >= IMG_H);
    img_d = oob_d ? '0 : IMG_AW'(iy * IMG_W + ix);
`else
    img_d = IMG_AW'(iy * IMG_W + ix);
`endif
    conv_d = pbase_d + PAR_AW'(int'(ky_d) * K + int'(kx_d));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      pbase_q <= '0;
      img_q   <= '0;
      conv_q  <= '0;
`ifdef NPU_CONV_READER_PAD_EN
      oob_q   <= 1'b0;
`endif
    end else if (load) begin
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      pbase_q <= pbase_d;
      img_q   <= img_d;
      conv_q  <= conv_d;
`ifdef NPU_CONV_READER_PAD_EN
      oob_q   <= oob_d;
`endif
    end
  end

  assign image_addr_o = img_q;
  assign conv_addr_o  = conv_q;
`ifdef NPU_CONV_READER_PAD_EN
  assign oob_o        = oob_q;
`endif
  assign first_tap_o  = (kx_q == '0) && (ky_q == '0);
  assign last_tap_o   = (kx_q == KW'(K - 1)) && (ky_q == KW'(K - 1));
  assign last_win_o   = (ox_q == XW'(OUT_W - 1)) && (oy_q == YW'(OUT_H - 1));

endmodule

// File: rtl/npu_conv_reader.sv
// Convolution-layer read sequencer: streams KxK taps to the MAC array, then writes back NCH accumulators.
// NPU_CONV_READER_PAD_EN enables "same" zero padding (out-of-image taps yield zero pixels).
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_READ  | issuing one tap address per cycle for the current window
// ST_DRAIN | letting RAM read, output register and MAC accumulate settle
// ST_WB    | writing the NCH accumulators to the store RAM
// ST_DONE  | one-cycle completion pulse
module npu_conv_reader import npu_pkg::*; #(
  parameter int NCH     = 4,
  parameter int DW      = 8,
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int K       = 3,
  parameter int IMG_AW  = 10,
  parameter int PAR_AW  = 15,
  parameter int ST_AW   = 14,
  parameter int ACC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  npu_conv_reader_if.master bus
);
  localparam int PLANE   = plane(IMG_W, IMG_H, K);
  localparam int DRAIN_N = 2 + ACC_LAT;
  localparam int DCW     = cw(DRAIN_N);
  localparam int RNW     = cw(NCH);

  state_e            state_q, state_d;
  logic [DCW-1:0]    drain_q, drain_d;
  logic [RNW-1:0]    wb_q, wb_d;
  logic [ST_AW-1:0]  win_q, win_d;
  logic [ST_AW-1:0]  obase_q, obase_d;
  logic [ST_AW-1:0]  st_addr_q, st_addr_d;
  logic              ag_init, ag_step, ag_next;
  logic              first_tap, last_tap, last_win, issue;

  logic              v1_q, f1_q, l1_q;
  logic              mac_valid_q, mac_first_q, mac_last_q;
  logic [NCH*DW-1:0] out_pixel_q;
  logic [DW-1:0]     out_param_q;
`ifdef NPU_CONV_READER_PAD_EN
  logic              oob, oob1_q;
`endif

  npu_win_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .IMG_AW (IMG_AW),
    .PAR_AW (PAR_AW)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .init_i       (ag_init),
    .step_i       (ag_step),
    .next_win_i   (ag_next),
    .param_base_i (bus.param_base),
    .image_addr_o (bus.image_ram_addr),
    .conv_addr_o  (bus.conv_ram_addr),
`ifdef NPU_CONV_READER_PAD_EN
    .oob_o        (oob),
`endif
    .first_tap_o  (first_tap),
    .last_tap_o   (last_tap),
    .last_win_o   (last_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      drain_q   <= '0;
      wb_q      <= '0;
      win_q     <= '0;
      obase_q   <= '0;
      st_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      wb_q      <= wb_d;
      win_q     <= win_d;
      obase_q   <= obase_d;
      st_addr_q <= st_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    wb_d      = wb_q;
    win_d     = win_q;
    obase_d   = obase_q;
    st_addr_d = st_addr_q;
    ag_init   = 1'b0;
    ag_step   = 1'b0;
    ag_next   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_READ;
          obase_d = bus.out_base;
          win_d   = '0;
          ag_init = 1'b1;
        end
      end
      ST_READ: begin
        if (last_tap) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          ag_step = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DCW'(DRAIN_N - 1)) begin
          state_d   = ST_WB;
          wb_d      = '0;
          // Window index equals oy*OUT_W+ox because windows run ox-fastest.
          st_addr_d = obase_q + win_q;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      ST_WB: begin
        st_addr_d = st_addr_q + ST_AW'(PLANE);
        if (wb_q == RNW'(NCH - 1)) begin
          if (last_win) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
            ag_next = 1'b1;
            win_d   = win_q + 1'b1;
          end
        end else begin
          wb_d = wb_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue = (state_q == ST_READ);

  // Two-stage tap pipeline: RAM read latency, then the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q        <= 1'b0;
      f1_q        <= 1'b0;
      l1_q        <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      out_pixel_q <= '0;
      out_param_q <= '0;
`ifdef NPU_CONV_READER_PAD_EN
      oob1_q      <= 1'b0;
`endif
    end else begin
      v1_q        <= issue;
      f1_q        <= issue && first_tap;
      l1_q        <= issue && last_tap;
      mac_valid_q <= v1_q;
      mac_first_q <= f1_q;
      mac_last_q  <= l1_q;
`ifdef NPU_CONV_READER_PAD_EN
      oob1_q      <= oob;
      if (v1_q) begin
        out_pixel_q <= oob1_q ? '0 : bus.read_image;
        out_param_q <= bus.read_conv;
      end
`else
      if (v1_q) begin
        out_pixel_q <= bus.read_image;
        out_param_q <= bus.read_conv;
      end
`endif
    end
  end

  assign bus.out_pixel      = out_pixel_q;
  assign bus.out_param      = out_param_q;
  assign bus.mac_valid      = mac_valid_q;
  assign bus.mac_first      = mac_first_q;
  assign bus.mac_last       = mac_last_q;
  assign bus.wr_en          = (state_q == ST_WB);
  assign bus.reg_num        = wb_q;
  assign bus.ram_store_addr = st_addr_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_npu_conv_reader.sv
// Directed bench for npu_conv_reader: NCH=4, 4x4 image, K=3, ACC_LAT=1.
// Build with NPU_CONV_READER_PAD_EN defined to exercise the zero-padding scenario instead.
module tb_npu_conv_reader;
  localparam int NCH    = 4;
  localparam int DW     = 8;
  localparam int IMG_AW = 10;
  localparam int PAR_AW = 15;
  localparam int ST_AW  = 14;

  logic clk = 1'b0;
  logic reset;
  int   nchk  = 0;
  int   npass = 0;

  npu_conv_reader_if #(
    .NCH(NCH), .DW(DW), .IMG_AW(IMG_AW), .PAR_AW(PAR_AW), .ST_AW(ST_AW)
  ) bus ();

  npu_conv_reader #(
    .NCH(NCH), .DW(DW), .IMG_W(4), .IMG_H(4), .K(3),
    .IMG_AW(IMG_AW), .PAR_AW(PAR_AW), .ST_AW(ST_AW), .ACC_LAT(1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pix(input int a);
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[c*8 +: 8] = 8'((a * 3 + c * 61 + 17) & 255);
    return r;
  endfunction

  function automatic logic [7:0] wgt(input int a);
    return 8'((a ^ 90) & 255);
  endfunction

  // One-cycle-latency image and parameter RAMs.
  always @(posedge clk) begin
    bus.read_image <= pix(int'(bus.image_ram_addr));
    bus.read_conv  <= wgt(int'(bus.conv_ram_addr));
  end

  task automatic chk(input string tag, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".img_addr"},  longint'(bus.image_ram_addr), 0);
    chk({tag, ".conv_addr"}, longint'(bus.conv_ram_addr), 0);
    chk({tag, ".out_pixel"}, longint'(bus.out_pixel), 0);
    chk({tag, ".out_param"}, longint'(bus.out_param), 0);
    chk({tag, ".mac_valid"}, longint'(bus.mac_valid), 0);
    chk({tag, ".mac_first"}, longint'(bus.mac_first), 0);
    chk({tag, ".mac_last"},  longint'(bus.mac_last), 0);
    chk({tag, ".wr_en"},     longint'(bus.wr_en), 0);
    chk({tag, ".reg_num"},   longint'(bus.reg_num), 0);
    chk({tag, ".st_addr"},   longint'(bus.ram_store_addr), 0);
    chk({tag, ".busy"},      longint'(bus.busy), 0);
    chk({tag, ".done"},      longint'(bus.done), 0);
  endtask

  // Start sampled at the next rising edge (cycle 0); returns early in cycle 1.
  task automatic pulse_start();
    bus.param_base = 15'd100;
    bus.out_base   = 14'd200;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Expected image address of tap j of window w in a valid-mode 2x2 output grid.
  function automatic int exp_img(input int w, input int j);
    return ((w / 2) + j / 3) * 4 + (w % 2) + j % 3;
  endfunction

  task automatic run_layer(input bit poke);
    pulse_start();
    for (int k = 1; k <= 66; k++) begin
      int w;
      int j;
      bit mv;
      bit wr;
      @(negedge clk);
      w  = (k - 1) / 16;
      j  = (k - 1) % 16;
      mv = (k <= 64) && (j >= 2) && (j <= 10);
      wr = (k <= 64) && (j >= 12);
      if (k <= 64 && j < 9) begin
        chk($sformatf("img_addr@%0d", k), longint'(bus.image_ram_addr), exp_img(w, j));
        chk($sformatf("conv_addr@%0d", k), longint'(bus.conv_ram_addr), 100 + j);
      end
      chk($sformatf("mac_valid@%0d", k), longint'(bus.mac_valid), longint'(mv));
      chk($sformatf("mac_first@%0d", k), longint'(bus.mac_first), longint'(mv && j == 2));
      chk($sformatf("mac_last@%0d", k),  longint'(bus.mac_last),  longint'(mv && j == 10));
      if (mv) begin
        chk($sformatf("out_pixel@%0d", k), longint'(bus.out_pixel), longint'(pix(exp_img(w, j - 2))));
        chk($sformatf("out_param@%0d", k), longint'(bus.out_param), longint'(wgt(100 + j - 2)));
      end
      chk($sformatf("wr_en@%0d", k), longint'(bus.wr_en), longint'(wr));
      if (wr) begin
        chk($sformatf("reg_num@%0d", k), longint'(bus.reg_num), j - 12);
        chk($sformatf("st_addr@%0d", k), longint'(bus.ram_store_addr), 200 + (j - 12) * 4 + w);
      end
      chk($sformatf("done@%0d", k), longint'(bus.done), longint'(k == 65));
      chk($sformatf("busy@%0d", k), longint'(bus.busy), longint'(k <= 65));
      if (poke && k == 20) begin
        bus.start      = 1'b1;
        bus.param_base = 15'd7;
        bus.out_base   = 14'd999;
      end
      if (k == 21) bus.start = 1'b0;
    end
  endtask

  task automatic reset_mid_wb();
    pulse_start();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 13) chk("mid.wr_en@13", longint'(bus.wr_en), 1);
      if (k == 14) reset = 1'b1;
      if (k == 15) chk_zero("mid_reset");
    end
    reset = 1'b0;
  endtask

`ifdef NPU_CONV_READER_PAD_EN
  task automatic run_pad();
    pulse_start();
    for (int k = 1; k <= 258; k++) begin
      int  j;
      int  ix;
      int  iy;
      int  a;
      bit  oob;
      @(negedge clk);
      if (k <= 9) begin
        j   = k - 1;
        ix  = j % 3 - 1;
        iy  = j / 3 - 1;
        oob = (ix < 0) || (iy < 0);
        a   = oob ? 0 : iy * 4 + ix;
        chk($sformatf("pad.img_addr@%0d", k), longint'(bus.image_ram_addr), a);
        chk($sformatf("pad.conv_addr@%0d", k), longint'(bus.conv_ram_addr), 100 + j);
      end
      if (k >= 3 && k <= 11) begin
        j   = k - 3;
        ix  = j % 3 - 1;
        iy  = j / 3 - 1;
        oob = (ix < 0) || (iy < 0);
        a   = oob ? 0 : iy * 4 + ix;
        chk($sformatf("pad.out_pixel@%0d", k), longint'(bus.out_pixel),
            oob ? 0 : longint'(pix(a)));
      end
      if (k <= 12)
        chk($sformatf("pad.mac_valid@%0d", k), longint'(bus.mac_valid), longint'(k >= 3 && k <= 11));
      chk($sformatf("pad.done@%0d", k), longint'(bus.done), longint'(k == 257));
      if (k >= 256)
        chk($sformatf("pad.busy@%0d", k), longint'(bus.busy), longint'(k <= 257));
    end
  endtask
`endif

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.param_base = '0;
    bus.out_base   = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
`ifdef NPU_CONV_READER_PAD_EN
    run_pad();
    reset_mid_wb();
    run_pad();
`else
    run_layer(1'b1);
    reset_mid_wb();
    run_layer(1'b0);
`endif
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
